// File: rtl/car_line_seq_if.sv
// Motor-controller handshake bundle for car_line_seq.
// master: the sensor/command side (drives start, abort, speed, sensors).
// slave:  the sequencer itself (drives md1..md4, state, done).
interface car_line_seq_if #(
  parameter int PWM_BITS = 8
);
  logic                start;
  logic                abort;
  logic [PWM_BITS-1:0] speed;
  logic                infL;
  logic                infR;
  logic                md1;
  logic                md2;
  logic                md3;
  logic                md4;
  logic [2:0]          state;
  logic                done;

  modport master (
    output start, abort, speed, infL, infR,
    input  md1, md2, md3, md4, state, done
  );

  modport slave (
    input  start, abort, speed, infL, infR,
    output md1, md2, md3, md4, state, done
  );
endinterface

// File: rtl/car_line_seq.sv
// car_line_seq: line-following car drive sequencer.
// Synchronises and debounces the IR sensors, runs the drive FSM and emits
// PWM-gated, registered H-bridge controls md1..md4.
// Optional feature macro: CAR_PIVOT_TURN_EN (inner wheel reverses during turns).
//
// state  | meaning
// IDLE   | motors off, waiting for start
// FWD    | both wheels forward at duty_q
// TURN_L | right wheel forward, left wheel off (or reverse when pivoting)
// TURN_R | left wheel forward, right wheel off (or reverse when pivoting)
// MARK   | both sensors on black, motors off, timing the stop marker
// HALT   | marker confirmed, motors off, done=1, waiting for start
module car_line_seq #(
  parameter int DEB_CYC  = 16,
  parameter int MARK_CYC = 1000,
  parameter int PWM_BITS = 8
) (
  input logic           clk,
  input logic           reset,
  car_line_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_TURN_L = 3'd2,
    S_TURN_R = 3'd3,
    S_MARK   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [15:0] DEB_TC  = 16'(DEB_CYC);
  localparam logic [15:0] MARK_TC = 16'(MARK_CYC - 1);

  state_t              state_q, state_n;
  logic [1:0]          sync1, sync2, prev, filt;
  logic [15:0]         deb_cnt, deb_nxt;
  logic [15:0]         mark_cnt, mark_n;
  logic [PWM_BITS-1:0] pwm_cnt, duty_q, duty_n;
  logic                pwm_on;
  logic                md1_n, md2_n, md3_n, md4_n;
  logic                md1_q, md2_q, md3_q, md4_q, done_q;

  // {L,R} bit order matches the 2-bit drive decode below.
  function automatic state_t decode(input logic [1:0] f);
    case (f)
      2'b00:   return S_FWD;
      2'b10:   return S_TURN_L;
      2'b01:   return S_TURN_R;
      default: return S_MARK;
    endcase
  endfunction

  // A new synced value counts as its own first stable sample.
  always_comb deb_nxt = (sync2 != prev) ? 16'd1 : deb_cnt + 16'd1;

  // Sensor synchroniser and debounce filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      prev    <= 2'b00;
      filt    <= 2'b00;
      deb_cnt <= 16'd0;
    end else begin
      sync1 <= {bus.infL, bus.infR};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 == filt) begin
        deb_cnt <= 16'd0;
      end else if (deb_nxt >= DEB_TC) begin
        filt    <= sync2;
        deb_cnt <= 16'd0;
      end else begin
        deb_cnt <= deb_nxt;
      end
    end
  end

  // Free-running PWM carrier.
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Next-state, duty and marker-count decode; abort overrides start and sensors.
  always_comb begin
    state_n = state_q;
    duty_n  = duty_q;
    mark_n  = mark_cnt;
    if (bus.abort) begin
      state_n = S_IDLE;
      mark_n  = 16'd0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state_n = S_FWD;
            duty_n  = bus.speed;
          end
        end
        S_FWD, S_TURN_L, S_TURN_R: begin
          state_n = decode(filt);
          if (state_n == S_MARK) mark_n = 16'd0;
        end
        S_MARK: begin
          if (filt == 2'b11) begin
            if (mark_cnt >= MARK_TC) begin
              state_n = S_HALT;
              mark_n  = 16'd0;
            end else begin
              mark_n = mark_cnt + 16'd1;
            end
          end else begin
            state_n = decode(filt);
            mark_n  = 16'd0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Duty compares against the duty in force after this edge so a fresh start drives at once.
  always_comb pwm_on = (pwm_cnt < duty_n);

  // Per-state wheel drive; forward and reverse of one wheel are never set together.
  always_comb begin
    md1_n = 1'b0;
    md2_n = 1'b0;
    md3_n = 1'b0;
    md4_n = 1'b0;
    case (state_n)
      S_FWD: begin
        md1_n = pwm_on;
        md3_n = pwm_on;
      end
      S_TURN_L: begin
        md3_n = pwm_on;
`ifdef CAR_PIVOT_TURN_EN
        md2_n = pwm_on;
`endif
      end
      S_TURN_R: begin
        md1_n = pwm_on;
`ifdef CAR_PIVOT_TURN_EN
        md4_n = pwm_on;
`endif
      end
      default: ;
    endcase
  end

  // FSM state and registered outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      mark_cnt <= 16'd0;
      md1_q    <= 1'b0;
      md2_q    <= 1'b0;
      md3_q    <= 1'b0;
      md4_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      duty_q   <= duty_n;
      mark_cnt <= mark_n;
      md1_q    <= md1_n;
      md2_q    <= md2_n;
      md3_q    <= md3_n;
      md4_q    <= md4_n;
      done_q   <= (state_n == S_HALT);
    end
  end

  assign bus.md1   = md1_q;
  assign bus.md2   = md2_q;
  assign bus.md3   = md3_q;
  assign bus.md4   = md4_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_car_line_seq.sv
// Directed testbench for car_line_seq with default parameters
// (DEB_CYC=16, MARK_CYC=1000, PWM_BITS=8).
module tb_car_line_seq;

  localparam int DEB  = 16;
  localparam int MARK = 1000;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  car_line_seq_if #(.PWM_BITS(8)) bus ();

  car_line_seq #(.DEB_CYC(DEB), .MARK_CYC(MARK), .PWM_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples both live 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      n_chk++;
      if (bus.state !== 3'd0 || {bus.md1, bus.md2, bus.md3, bus.md4} !== 4'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: state=%0d md=%b done=%b, required state=0 md=0000 done=0",
                 i, bus.state, {bus.md1, bus.md2, bus.md3, bus.md4}, bus.done);
      end
    end
  endtask

  task automatic test_fwd_duty();
    int c1, c2, c3, c4;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    bus.speed = 8'h80;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_fail++;
      $display("FAIL fwd_entry: state=%0d required 1", bus.state);
    end
    for (int i = 0; i < 512; i++) begin
      c1 += int'(bus.md1); c2 += int'(bus.md2); c3 += int'(bus.md3); c4 += int'(bus.md4);
      tick();
    end
    n_chk++;
    if (c1 != 256 || c3 != 256 || c2 != 0 || c4 != 0) begin
      n_fail++;
      $display("FAIL fwd_duty: md1=%0d md2=%0d md3=%0d md4=%0d, required 256 0 256 0", c1, c2, c3, c4);
    end
  endtask

  task automatic test_debounce_turn();
    int c1, c2, c3, c4;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    bus.infL = 1'b1;
    for (int i = 0; i < DEB - 1; i++) tick();
    bus.infL = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_chk++;
      if (bus.state !== 3'd1) begin
        n_fail++;
        $display("FAIL glitch_reject: cycle %0d state=%0d required 1", i, bus.state);
      end
    end
    bus.infL = 1'b1;
    for (int i = 0; i < DEB + 2; i++) tick();
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_fail++;
      $display("FAIL turn_latency_early: state=%0d required 1", bus.state);
    end
    tick();
    n_chk++;
    if (bus.state !== 3'd2 || bus.md1 !== 1'b0) begin
      n_fail++;
      $display("FAIL turn_l_entry: state=%0d md1=%b, required 2 0", bus.state, bus.md1);
    end
    for (int i = 0; i < 256; i++) begin
      c1 += int'(bus.md1); c2 += int'(bus.md2); c3 += int'(bus.md3); c4 += int'(bus.md4);
      tick();
    end
    n_chk++;
`ifdef CAR_PIVOT_TURN_EN
    if (c1 != 0 || c2 != 128 || c3 != 128 || c4 != 0) begin
`else
    if (c1 != 0 || c2 != 0 || c3 != 128 || c4 != 0) begin
`endif
      n_fail++;
      $display("FAIL turn_l_drive: md1=%0d md2=%0d md3=%0d md4=%0d", c1, c2, c3, c4);
    end
    bus.infL = 1'b0;
    for (int i = 0; i < DEB + 6; i++) tick();
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_fail++;
      $display("FAIL turn_l_exit: state=%0d required 1", bus.state);
    end
  endtask

  task automatic test_mark_halt();
    int mark_at, halt_at;
    mark_at = -1; halt_at = -1;
    bus.infL = 1'b1;
    bus.infR = 1'b1;
    for (int i = 1; i <= MARK + DEB + 40 && halt_at < 0; i++) begin
      tick();
      if (bus.state === 3'd4 && mark_at < 0) mark_at = i;
      if (bus.state === 3'd5) halt_at = i;
      if (bus.state === 3'd4 && {bus.md1, bus.md2, bus.md3, bus.md4} !== 4'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mark_motors: md=%b required 0000", {bus.md1, bus.md2, bus.md3, bus.md4});
      end
    end
    n_chk++;
    if (mark_at != DEB + 3) begin
      n_fail++;
      $display("FAIL mark_entry: cycle=%0d required %0d", mark_at, DEB + 3);
    end
    n_chk++;
    if (halt_at != DEB + 3 + MARK) begin
      n_fail++;
      $display("FAIL halt_entry: cycle=%0d required %0d", halt_at, DEB + 3 + MARK);
    end
    bus.infL = 1'b0;
    bus.infR = 1'b0;
    for (int i = 0; i < DEB + 6; i++) tick();
    n_chk++;
    if (bus.state !== 3'd5 || bus.done !== 1'b1 || {bus.md1, bus.md2, bus.md3, bus.md4} !== 4'b0) begin
      n_fail++;
      $display("FAIL halt_hold: state=%0d done=%b md=%b, required 5 1 0000",
               bus.state, bus.done, {bus.md1, bus.md2, bus.md3, bus.md4});
    end
    bus.speed = 8'h80;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_chk++;
    if (bus.state !== 3'd1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_restart: state=%0d done=%b, required 1 0", bus.state, bus.done);
    end
  endtask

  task automatic test_short_mark();
    bit saw_mark, saw_halt;
    saw_mark = 1'b0; saw_halt = 1'b0;
    bus.infL = 1'b1;
    bus.infR = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.state === 3'd4) saw_mark = 1'b1;
      if (bus.state === 3'd5) saw_halt = 1'b1;
    end
    bus.infL = 1'b0;
    bus.infR = 1'b0;
    for (int i = 0; i < DEB + 6; i++) begin
      tick();
      if (bus.state === 3'd5) saw_halt = 1'b1;
    end
    n_chk++;
    if (!saw_mark || saw_halt || bus.state !== 3'd1) begin
      n_fail++;
      $display("FAIL short_mark: saw_mark=%0d saw_halt=%0d state=%0d, required 1 0 1",
               saw_mark, saw_halt, bus.state);
    end
  endtask

  task automatic test_abort();
    bus.infR = 1'b1;
    for (int i = 0; i < DEB + 4; i++) tick();
    n_chk++;
    if (bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL turn_r_entry: state=%0d required 3", bus.state);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    n_chk++;
    if (bus.state !== 3'd0 || {bus.md1, bus.md2, bus.md3, bus.md4} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_turn_r: state=%0d md=%b, required 0 0000",
               bus.state, {bus.md1, bus.md2, bus.md3, bus.md4});
    end
    tick();
    n_chk++;
    if (bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_over_start: state=%0d required 0", bus.state);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.infR  = 1'b0;
    for (int i = 0; i < DEB + 6; i++) tick();
  endtask

  task automatic test_duty_limits();
    int c1, c3;
    c1 = 0; c3 = 0;
    bus.speed = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      c1 += int'(bus.md1); c3 += int'(bus.md3);
      tick();
    end
    n_chk++;
    if (bus.state !== 3'd1 || c1 != 0 || c3 != 0) begin
      n_fail++;
      $display("FAIL duty_zero: state=%0d md1=%0d md3=%0d, required 1 0 0", bus.state, c1, c3);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    c1 = 0; c3 = 0;
    bus.speed = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      c1 += int'(bus.md1); c3 += int'(bus.md3);
      tick();
    end
    n_chk++;
    if (c1 != 255 || c3 != 255) begin
      n_fail++;
      $display("FAIL duty_full: md1=%0d md3=%0d, required 255 255", c1, c3);
    end
  endtask

  task automatic test_random_invariant();
    int bad;
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        bus.infL = 1'($urandom_range(0, 1));
        bus.infR = 1'($urandom_range(0, 1));
      end
      bus.abort = ($urandom_range(0, 63) == 0);
      bus.start = ($urandom_range(0, 15) == 0);
      bus.speed = 8'($urandom_range(0, 255));
      tick();
      n_chk++;
`ifdef CAR_PIVOT_TURN_EN
      if ((bus.md1 & bus.md2) || (bus.md3 & bus.md4)) begin
`else
      if ((bus.md1 & bus.md2) || (bus.md3 & bus.md4) || bus.md2 || bus.md4) begin
`endif
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL shoot_through: cycle %0d md=%b state=%0d",
                   i, {bus.md1, bus.md2, bus.md3, bus.md4}, bus.state);
      end
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.speed = 8'h00;
    bus.infL  = 1'b0;
    bus.infR  = 1'b0;
    test_reset();
    test_fwd_duty();
    test_debounce_turn();
    test_mark_halt();
    test_short_mark();
    test_abort();
    test_duty_limits();
    test_random_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
